// File: rtl/spmm_pkg.sv
// spmm_pkg: shared sizes, element type and bank state encoding for the SpMM RHS buffer
package spmm_pkg;
  localparam int N = 16;
  localparam int W = 8;
  localparam int R = 4;
  localparam int LGN = $clog2(N);
  localparam int NB = N / R;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  typedef logic [W-1:0] data_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, LOADING = 2'd1, FULL = 2'd2, ACTIVE = 2'd3} bank_state_e;
  function automatic logic [LGN-1:0] row_of(input logic [BW-1:0] b, input int k);
    return LGN'(int'(b) * R + k);
  endfunction
endpackage

// File: rtl/spmm_rhs_bank.sv
// spmm_rhs_bank: one NxN element store, R-row group write per beat, N-lane gather read
// ports: clk; wr_en/beat/wr_data write rows beat*R..beat*R+R-1; rd_row/rd_col -> rd_data (combinational)
module spmm_rhs_bank
  import spmm_pkg::*;
(
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [BW-1:0]             beat,
  input  data_t [R-1:0][N-1:0]      wr_data,
  input  logic  [N-1:0][LGN-1:0]    rd_row,
  input  logic  [LGN-1:0]           rd_col,
  output data_t [N-1:0]             rd_data
);
  data_t [N-1:0] mem [N];
  always_ff @(posedge clk)
    if (wr_en)
      for (int k = 0; k < R; k++) mem[row_of(beat, k)] <= wr_data[k];
  for (genvar k = 0; k < N; k++) begin : g_rd
    assign rd_data[k] = mem[rd_row[k]][rd_col];
  end
endmodule

// File: rtl/spmm_rhs_pingpong_buffer.sv
// spmm_rhs_pingpong_buffer: double-buffered dense RHS store with load/compute handshakes and weight-stationary reuse
// ports: clk, rst_n (async, active-low); load side rhs_ready/rhs_start/rhs_data;
// compute side cmp_ready/cmp_acquire/cmp_release/cmp_keep; gather read rd_row/rd_col -> rd_data (1-cycle); bank_state debug
module spmm_rhs_pingpong_buffer
  import spmm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      rhs_ready,
  input  logic                      rhs_start,
  input  data_t [R-1:0][N-1:0]      rhs_data,
  output logic                      cmp_ready,
  input  logic                      cmp_acquire,
  input  logic                      cmp_release,
  input  logic                      cmp_keep,
  input  logic  [N-1:0][LGN-1:0]    rd_row,
  input  logic  [LGN-1:0]           rd_col,
  output data_t [N-1:0]             rd_data,
  output logic  [1:0][1:0]          bank_state
);
  if (N % R != 0 || (N & (N - 1)) != 0 || N < 4) begin : g_bad_params
    $error("spmm_rhs_pingpong_buffer: N must be a power of 2 >= 4 and divisible by R");
  end
  bank_state_e st [2];
  logic wr_ptr, rd_ptr, loading, active, act_idx, start, acq, rel, last;
  logic [BW-1:0] beat;
  data_t [N-1:0] bank_rd [2];
  assign loading   = st[0] == LOADING || st[1] == LOADING;
  assign active    = st[0] == ACTIVE || st[1] == ACTIVE;
  assign act_idx   = st[1] == ACTIVE;
  assign rhs_ready = st[wr_ptr] == EMPTY && !loading;
  assign cmp_ready = !active && st[rd_ptr] == FULL;
  assign start     = rhs_start && rhs_ready;
  assign acq       = cmp_acquire && cmp_ready;
  assign rel       = cmp_release && active;
  assign last      = beat == BW'(NB - 1);
  assign bank_state = {st[1], st[0]};
  // the loading bank is always bank[wr_ptr]; beat is 0 whenever no load is in flight
  for (genvar b = 0; b < 2; b++) begin : g_bank
    spmm_rhs_bank u_bank (
      .clk     (clk),
      .wr_en   ((start || loading) && wr_ptr == 1'(b)),
      .beat    (beat),
      .wr_data (rhs_data),
      .rd_row  (rd_row),
      .rd_col  (rd_col),
      .rd_data (bank_rd[b])
    );
  end
  // load, acquire and release always touch different banks, so their updates never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]   <= EMPTY;
      st[1]   <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      beat    <= '0;
      rd_data <= '0;
    end else begin
      if (start || loading) begin
        beat       <= last ? '0 : beat + 1'b1;
        st[wr_ptr] <= last ? FULL : LOADING;
        if (last) wr_ptr <= ~wr_ptr;
      end
      if (rel) begin
        st[act_idx] <= cmp_keep ? FULL : EMPTY;
        if (!cmp_keep) rd_ptr <= ~rd_ptr;
      end
      if (acq) st[rd_ptr] <= ACTIVE;
      rd_data <= active ? bank_rd[act_idx] : '0;
    end
  end
endmodule
